// File: rtl/maxpool_pkg.sv
// maxpool_pkg: shared types, default geometry and the signed-max helper for
// the maxpool_stream block. The defaults match the conv stage that feeds it.
package maxpool_pkg;

  localparam int DEF_WIDTH  = 16;
  localparam int DEF_LENY   = 32;
  localparam int DEF_POOL   = 2;
  localparam int DEF_LOGLEN = 5;

  // Results per vector, counting a trailing partial window.
  localparam int NOUT    = (DEF_LENY + DEF_POOL - 1) / DEF_POOL;
  // Width of the in-window counter.
  localparam int LOGPOOL = $clog2(DEF_POOL + 1);

  typedef logic signed [DEF_WIDTH-1:0] sample_t;

  function automatic sample_t smax(input sample_t a, input sample_t b);
    return (b > a) ? b : a;
  endfunction

endpackage

// File: rtl/maxpool_stream_fifo.sv
// pool_out_fifo: 2-entry output queue for maxpool_stream. Its only readiness
// indicator is the registered occupancy count, so the producer never sees a
// combinational path from the downstream ready.
module pool_out_fifo
  import maxpool_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_push_valid,
  input  logic signed [WIDTH-1:0] i_push_data,
  output logic                    o_pop_valid,
  input  logic                    i_pop_ready,
  output logic signed [WIDTH-1:0] o_pop_data,
  output logic [1:0]              o_count
);

  logic [1:0]              r_count;
  logic signed [WIDTH-1:0] r_head;
  logic signed [WIDTH-1:0] r_tail;
  logic                    w_push;
  logic                    w_pop;

  assign w_push      = i_push_valid && (r_count != 2'd2);
  assign w_pop       = i_pop_ready && (r_count != 2'd0);
  assign o_pop_valid = (r_count != 2'd0);
  assign o_pop_data  = r_head;
  assign o_count     = r_count;

  // Occupancy and head entry; the head is what downstream sees.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= 2'd0;
      r_head  <= '0;
    end else begin
      case ({w_push, w_pop})
        2'b10: begin
          if (r_count == 2'd0) r_head <= i_push_data;
          r_count <= r_count + 2'd1;
        end
        2'b01: begin
          r_head  <= r_tail;
          r_count <= r_count - 2'd1;
        end
        // Push and pop together only happen at count 1: the new beat becomes head.
        2'b11:   r_head <= i_push_data;
        default: ;
      endcase
    end
  end

  // Second entry, only written when the head is already occupied and stays.
  always_ff @(posedge clk) begin
    if (w_push && !w_pop && (r_count == 2'd1)) r_tail <= i_push_data;
  end

endmodule

// File: rtl/maxpool_stream.sv
// maxpool_stream: streaming 1-D signed max-pool over non-overlapping windows
// of POOL samples per LENY-sample vector; a trailing partial window is closed
// at the vector end. Build option: define MAXPOOL_SKID_EN to place the
// 2-entry pool_out_fifo on the output and cut the m_ready_z -> s_ready_y path.
module maxpool_stream
  import maxpool_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int LENY   = DEF_LENY,
  parameter int POOL   = DEF_POOL,
  parameter int LOGLEN = DEF_LOGLEN
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic signed [WIDTH-1:0] s_data_in_y,
  input  logic                    s_valid_y,
  output logic                    s_ready_y,
  output logic signed [WIDTH-1:0] m_data_out_z,
  output logic                    m_valid_z,
  input  logic                    m_ready_z
);

  localparam int CNT_W = $clog2(POOL + 1);
  localparam logic [CNT_W-1:0]  LAST_WIN = CNT_W'(POOL - 1);
  localparam logic [CNT_W-1:0]  WIN_ONE  = CNT_W'(1);
  localparam logic [LOGLEN-1:0] LAST_POS = LOGLEN'(LENY - 1);
  localparam logic [LOGLEN-1:0] POS_ONE  = LOGLEN'(1);

  function automatic logic signed [WIDTH-1:0] max_sel(
    input logic signed [WIDTH-1:0] a,
    input logic signed [WIDTH-1:0] b
  );
    return (b > a) ? b : a;
  endfunction

  logic [CNT_W-1:0]        r_win_cnt_p0;
  logic [LOGLEN-1:0]       r_pos_p0;
  logic signed [WIDTH-1:0] r_max_p0;
  logic                    w_in_fire;
  logic                    w_close;
  logic                    w_push;
  logic signed [WIDTH-1:0] w_cand;

  // The first beat of a window seeds the max, so a closing beat at win 0
  // (POOL==1 or a one-sample tail window) passes straight through.
  assign w_close   = (r_win_cnt_p0 == LAST_WIN) || (r_pos_p0 == LAST_POS);
  assign w_cand    = (r_win_cnt_p0 == '0) ? s_data_in_y : max_sel(r_max_p0, s_data_in_y);
  assign w_in_fire = s_valid_y && s_ready_y;
  assign w_push    = w_in_fire && w_close;

  // Stage p0: window/vector position counters and running max.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_win_cnt_p0 <= '0;
      r_pos_p0     <= '0;
      r_max_p0     <= '0;
    end else if (w_in_fire) begin
      r_max_p0 <= w_cand;
      if (w_close) r_win_cnt_p0 <= '0;
      else         r_win_cnt_p0 <= r_win_cnt_p0 + WIN_ONE;
      if (r_pos_p0 == LAST_POS) r_pos_p0 <= '0;
      else                      r_pos_p0 <= r_pos_p0 + POS_ONE;
    end
  end

`ifdef MAXPOOL_SKID_EN
  logic [1:0] w_fifo_count;

  // Closing beats need a free FIFO slot; decided from registered occupancy only.
  assign s_ready_y = !reset && (!w_close || (w_fifo_count != 2'd2));

  // Stage p1: pooled results queued for downstream.
  pool_out_fifo #(
    .WIDTH (WIDTH)
  ) u_out_fifo (
    .clk          (clk),
    .reset        (reset),
    .i_push_valid (w_push),
    .i_push_data  (w_cand),
    .o_pop_valid  (m_valid_z),
    .i_pop_ready  (m_ready_z),
    .o_pop_data   (m_data_out_z),
    .o_count      (w_fifo_count)
  );
`else
  logic signed [WIDTH-1:0] r_data_p1;
  logic                    r_vld_p1;

  // A closing beat may enter when the output register is empty or draining now.
  assign s_ready_y = !reset && (!w_close || !r_vld_p1 || m_ready_z);

  // Stage p1: single output register, held while downstream stalls.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_vld_p1  <= 1'b0;
      r_data_p1 <= '0;
    end else if (w_push) begin
      r_vld_p1  <= 1'b1;
      r_data_p1 <= w_cand;
    end else if (m_ready_z) begin
      r_vld_p1  <= 1'b0;
    end
  end

  assign m_valid_z    = r_vld_p1;
  assign m_data_out_z = r_data_p1;
`endif

endmodule

// File: tb/tb_maxpool_stream.sv
// tb_maxpool_stream: directed and randomised checks of maxpool_stream.
// Main instance LENY=32/POOL=2, plus LENY=5/POOL=2 (partial window) and
// LENY=3/POOL=1 (pass-through). Works with MAXPOOL_SKID_EN defined or not.
module tb_maxpool_stream;
  import maxpool_pkg::*;

  localparam int W  = DEF_WIDTH;
  localparam int LA = 32;
  localparam int PA = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset = 1'b1;

  sample_t a_din = '0, a_dout;
  logic    a_sv = 1'b0, a_sr, a_mv, a_mr = 1'b0;
  sample_t b_din = '0, b_dout;
  logic    b_sv = 1'b0, b_sr, b_mv, b_mr = 1'b1;
  sample_t c_din = '0, c_dout;
  logic    c_sv = 1'b0, c_sr, c_mv, c_mr = 1'b1;

  maxpool_stream #(.WIDTH(W), .LENY(LA), .POOL(PA), .LOGLEN(5)) u_a (
    .clk(clk), .reset(reset), .s_data_in_y(a_din), .s_valid_y(a_sv), .s_ready_y(a_sr),
    .m_data_out_z(a_dout), .m_valid_z(a_mv), .m_ready_z(a_mr));
  maxpool_stream #(.WIDTH(W), .LENY(5), .POOL(2), .LOGLEN(3)) u_b (
    .clk(clk), .reset(reset), .s_data_in_y(b_din), .s_valid_y(b_sv), .s_ready_y(b_sr),
    .m_data_out_z(b_dout), .m_valid_z(b_mv), .m_ready_z(b_mr));
  maxpool_stream #(.WIDTH(W), .LENY(3), .POOL(1), .LOGLEN(2)) u_c (
    .clk(clk), .reset(reset), .s_data_in_y(c_din), .s_valid_y(c_sv), .s_ready_y(c_sr),
    .m_data_out_z(c_dout), .m_valid_z(c_mv), .m_ready_z(c_mr));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input logic signed [31:0] obs,
                           input logic signed [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Golden model for instance A, fed from transfers seen at the negedge
  // before the edge on which they happen.
  int      mpos = 0;
  int      n_beats = 0;
  sample_t mcur = '0;
  sample_t exp_q[$];
  sample_t got_q[$];
  sample_t b_got[$];

  always @(negedge clk) begin
    if (!reset) begin
      if (a_sv && a_sr) begin
        if ((mpos % PA) == 0) mcur = a_din;
        else if (a_din > mcur) mcur = a_din;
        if (((mpos % PA) == PA - 1) || (mpos == LA - 1)) exp_q.push_back(mcur);
        mpos = (mpos == LA - 1) ? 0 : mpos + 1;
        n_beats++;
      end
      if (a_mv && a_mr) got_q.push_back(a_dout);
      if (b_mv && b_mr) b_got.push_back(b_dout);
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic sample_t rnd_sample();
    case ($urandom_range(0, 7))
      0:       return -16'sd32768;
      1:       return 16'sd32767;
      2:       return -16'sd3;
      default: return W'($urandom);
    endcase
  endfunction

  task automatic drain_a();
    step();
    a_sv = 1'b0;
    a_mr = 1'b1;
    repeat (4) step();
  endtask

  task automatic fill_vector();
    int g;
    g = 0;
    a_mr = 1'b1;
    while (mpos != 0 && g < 200) begin
      step();
      a_sv  = 1'b1;
      a_din = rnd_sample();
      @(negedge clk);
      #1;
      g++;
    end
    check_val("fill_in_budget", int'(g < 200), 1);
  endtask

  task automatic cmp_queues(input string tag);
    int bad0;
    check_val({tag, "_count"}, got_q.size(), exp_q.size());
    bad0 = n_bad;
    foreach (got_q[i])
      if (i < exp_q.size() && n_bad == bad0) check_val(tag, int'(got_q[i]), int'(exp_q[i]));
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic rnd_phase(input int nbeats, input int pv, input int pr);
    int start;
    int g;
    start = n_beats;
    g = 0;
    while ((n_beats - start) < nbeats && g < 40000) begin
      step();
      a_sv  = ($urandom_range(0, 99) < pv);
      a_din = rnd_sample();
      a_mr  = ($urandom_range(0, 99) < pr);
      g++;
    end
    check_val("rnd_in_budget", int'(g < 40000), 1);
  endtask

  task automatic pair_check(input string tag, input sample_t x, input sample_t y, input sample_t e);
    a_mr = 1'b1;
    step(); a_sv = 1'b1; a_din = x;
    step(); a_din = y;
    step(); a_sv = 1'b0;
    @(negedge clk);
    check_val({tag, "_vld"}, int'(a_mv), 1);
    check_val(tag, int'(a_dout), int'(e));
  endtask

  int acc;
  int g;
  int bv[10] = '{1, 2, 3, 4, 9, 8, 6, -1, -5, 3};
  int be[6]  = '{2, 4, 9, 8, -1, 3};
`ifdef MAXPOOL_SKID_EN
  localparam int STALL_ACC = 5;
`else
  localparam int STALL_ACC = 3;
`endif

  initial begin
    // T1: reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_ready_low", int'(a_sr), 0);
    check_val("rst_valid", int'(a_mv), 0);
    check_val("rst_data", int'(a_dout), 0);
    step(); reset = 1'b0;
    @(negedge clk);
    check_val("post_rst_ready", int'(a_sr), 1);
    check_val("post_rst_valid", int'(a_mv), 0);
    check_val("post_rst_data", int'(a_dout), 0);

    // T2: back-to-back beats, results one cycle after beats 2 and 4
    a_mr = 1'b1;
    step(); a_sv = 1'b1; a_din = 16'sd5;
    @(negedge clk); check_val("t2_b1_vld", int'(a_mv), 0);
    step(); a_din = -16'sd3;
    @(negedge clk); check_val("t2_b2_vld", int'(a_mv), 0);
    step(); a_din = 16'sd0;
    @(negedge clk); check_val("t2_r1_vld", int'(a_mv), 1);
    check_val("t2_r1", int'(a_dout), 5);
    step(); a_din = 16'sd7;
    @(negedge clk); check_val("t2_b4_vld", int'(a_mv), 0);
    step(); a_sv = 1'b0;
    @(negedge clk); check_val("t2_r2_vld", int'(a_mv), 1);
    check_val("t2_r2", int'(a_dout), 7);
    fill_vector();
    drain_a();
    check_val("t2_nout", got_q.size(), 16);
    check_val("t2_q0", int'(got_q[0]), 5);
    check_val("t2_q1", int'(got_q[1]), 7);
    cmp_queues("t2_vec");

    // T4: signed comparisons at full width
    pair_check("t4_neg", -16'sd100, -16'sd200, -16'sd100);
    pair_check("t4_neg_rev", -16'sd200, -16'sd100, -16'sd100);
    pair_check("t4_extremes", -16'sd32768, 16'sd32767, 16'sd32767);
    pair_check("t4_m1_min", -16'sd1, -16'sd32768, -16'sd1);
    pair_check("t4_tie", 16'sd3, 16'sd3, 16'sd3);
    fill_vector();
    drain_a();
    cmp_queues("t4_vec");

    // T5: backpressure with the output stalled for 10 cycles
    acc = 0;
    step(); a_mr = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) step();
      a_sv  = 1'b1;
      a_din = W'((acc + 1) * 10);
      @(negedge clk);
      if (a_sr) acc++;
      if (i == 5) check_val("t5_hold_mid", int'(a_dout), 20);
    end
    check_val("t5_accepted", acc, STALL_ACC);
    check_val("t5_ready_low", int'(a_sr), 0);
    check_val("t5_hold_vld", int'(a_mv), 1);
    check_val("t5_hold_data", int'(a_dout), 20);
    g = 0;
    step(); a_mr = 1'b1;
    while (acc < 6 && g < 50) begin
      if (g > 0) step();
      a_sv  = 1'b1;
      a_din = W'((acc + 1) * 10);
      @(negedge clk);
      if (a_sr) acc++;
      g++;
    end
    #1;
    check_val("t5_release_budget", int'(g < 50), 1);
    fill_vector();
    drain_a();
    check_val("t5_q0", int'(got_q[0]), 20);
    check_val("t5_q1", int'(got_q[1]), 40);
    check_val("t5_q2", int'(got_q[2]), 60);
    cmp_queues("t5_vec");

    // T3: LENY=5 partial window, second vector restarts its window
    for (int i = 0; i < 10; i++) begin
      step(); b_sv = 1'b1; b_din = W'(bv[i]);
    end
    step(); b_sv = 1'b0;
    repeat (3) step();
    check_val("t3_count", b_got.size(), 6);
    for (int i = 0; i < 6; i++) check_val($sformatf("t3_r%0d", i), int'(b_got[i]), be[i]);

    // POOL=1: pass-through, one cycle of latency
    step(); c_sv = 1'b1; c_din = 16'sd3;
    @(negedge clk); check_val("p1_idle", int'(c_mv), 0);
    step(); c_din = -16'sd4;
    @(negedge clk); check_val("p1_r0", int'(c_dout), 3);
    step(); c_din = 16'sd5;
    @(negedge clk); check_val("p1_r1", int'(c_dout), -4);
    step(); c_sv = 1'b0;
    @(negedge clk); check_val("p1_r2", int'(c_dout), 5);
    check_val("p1_r2_vld", int'(c_mv), 1);
    step();
    @(negedge clk); check_val("p1_empty", int'(c_mv), 0);

    // T6: random traffic, reset mid-vector, more random traffic
    rnd_phase(100 * LA, 80, 70);
    a_mr = 1'b0;
    g = 0;
    while ((mpos % PA) != 1 && g < 100) begin
      step();
      a_sv  = 1'b1;
      a_din = rnd_sample();
      @(negedge clk);
      #1;
      g++;
    end
    step(); reset = 1'b1; a_sv = 1'b0;
    check_val("t6_pre_le", int'(got_q.size() <= exp_q.size()), 1);
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      if (got_q[i] !== exp_q[i] || i == got_q.size() - 1)
        check_val("t6_pre_rst", int'(got_q[i]), int'(exp_q[i]));
    got_q.delete();
    exp_q.delete();
    mpos = 0;
    @(negedge clk); check_val("t6_rst_ready", int'(a_sr), 0);
    step(); reset = 1'b0; a_mr = 1'b1;
    @(negedge clk);
    check_val("t6_rst_vld", int'(a_mv), 0);
    check_val("t6_rst_data", int'(a_dout), 0);
    rnd_phase(212 * LA, 60, 50);
    fill_vector();
    drain_a();
    cmp_queues("t6_post");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
